// File: rtl/motor_giro.sv
// -----------------------------------------------------------------------------
// motor_giro
//
// Full-step stepper-motor sequencer. It takes the debounced key value
// (1..9 revolutions) from the keypad decoder and drives the four coil phases
// of the motor driver for that many full revolutions. One command is accepted
// per key press: the key must be seen released (value 0) before a new value is
// taken. Busy and completion status go to the display/control logic.
//
// Parameters
//   PASSOS_POR_GIRO : full steps per motor revolution (>= 2)
//   DIV_PASSO       : clock cycles per motor step (>= 2)
//
// Ports
//   clock_in            in   system clock, rising edge
//   reset_in            in   asynchronous reset, active low
//   numgiro_in  [3:0]   in   key value: 0 = no key, 1..9 = command, 10..15 ignored
//   sentido_in          in   direction, sampled at accept (0 fwd, 1 rev)
//   parada_in           in   synchronous emergency stop, active high
//   fase_out    [3:0]   out  coil phases, one-hot while running, 0000 otherwise
//   ocupado_out         out  high while running
//   giros_restantes_out [3:0] out  revolutions left, including the current one
//   fim_out             out  one-cycle pulse on normal completion
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module motor_giro #(
  parameter int PASSOS_POR_GIRO = 48,
  parameter int DIV_PASSO       = 50000
) (
  input  logic       clock_in,
  input  logic       reset_in,
  input  logic [3:0] numgiro_in,
  input  logic       sentido_in,
  input  logic       parada_in,
  output logic [3:0] fase_out,
  output logic       ocupado_out,
  output logic [3:0] giros_restantes_out,
  output logic       fim_out
);

  // Counter widths. The step counter is sized to hold PASSOS_POR_GIRO itself.
  localparam int DIV_W   = (DIV_PASSO > 1) ? $clog2(DIV_PASSO) : 1;
  localparam int PASSO_W = $clog2(PASSOS_POR_GIRO + 1);

  localparam logic [DIV_W-1:0]   DIV_MAX   = DIV_W'(DIV_PASSO - 1);
  localparam logic [PASSO_W-1:0] PASSO_MAX = PASSO_W'(PASSOS_POR_GIRO - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers and next-state values
  // ---------------------------------------------------------------------------
  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [PASSO_W-1:0]   passo_q, passo_d;
  logic                 sentido_q, sentido_d;
  logic                 armado_q, armado_d;
  logic [3:0]           fase_q, fase_d;
  logic [3:0]           giros_q, giros_d;
  logic                 ocupado_q, ocupado_d;
  logic                 fim_q, fim_d;

  // ---------------------------------------------------------------------------
  // Shared decode
  // ---------------------------------------------------------------------------
  logic tecla_solta;   // key released (value 0)
  logic tecla_valida;  // key holds a legal command 1..9
  logic aceita;        // command accepted on this edge
  logic passo_term;    // divider at terminal count: take a step this edge
  logic giro_term;     // this step closes a revolution
  logic conclui;       // this step closes the last revolution (normal end)

  assign tecla_solta  = (numgiro_in == 4'd0);
  assign tecla_valida = (numgiro_in >= 4'd1) && (numgiro_in <= 4'd9);

  assign aceita = (state_q == IDLE) && armado_q && tecla_valida && !parada_in;

  assign passo_term = (div_q == DIV_MAX);
  assign giro_term  = passo_term && (passo_q == PASSO_MAX);

  // parada_in wins over a simultaneous completion, so it is excluded here.
  assign conclui = (state_q == RUN) && !parada_in && giro_term &&
                   (giros_q == 4'd1);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q   <= IDLE;
      div_q     <= '0;
      passo_q   <= '0;
      sentido_q <= 1'b0;
      armado_q  <= 1'b0;
      fase_q    <= 4'b0000;
      giros_q   <= 4'd0;
      ocupado_q <= 1'b0;
      fim_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      passo_q   <= passo_d;
      sentido_q <= sentido_d;
      armado_q  <= armado_d;
      fase_q    <= fase_d;
      giros_q   <= giros_d;
      ocupado_q <= ocupado_d;
      fim_q     <= fim_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (aceita) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (parada_in || conclui) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    div_d     = div_q;
    passo_d   = passo_q;
    sentido_d = sentido_q;
    fase_d    = fase_q;
    giros_d   = giros_q;
    fim_d     = 1'b0;

    // armado tracks the key in every state: released sets it, accept clears
    // it. A key held across reset or across a finished run is therefore never
    // taken twice. Accept and release are mutually exclusive.
    if (tecla_solta) begin
      armado_d = 1'b1;
    end else if (aceita) begin
      armado_d = 1'b0;
    end else begin
      armado_d = armado_q;
    end

    unique case (state_q)
      IDLE: begin
        if (aceita) begin
          giros_d   = numgiro_in;
          sentido_d = sentido_in;
          div_d     = '0;
          passo_d   = '0;
          fase_d    = 4'b0001;
        end
      end

      RUN: begin
        if (parada_in) begin
          // Emergency stop: abandon the command, no completion pulse.
          div_d   = '0;
          passo_d = '0;
          fase_d  = 4'b0000;
          giros_d = 4'd0;
        end else begin
          div_d = passo_term ? '0 : div_q + 1'b1;

          if (passo_term) begin
            // Forward rotates the one-hot phase left, reverse rotates right.
            fase_d = sentido_q ? {fase_q[0], fase_q[3:1]}
                               : {fase_q[2:0], fase_q[3]};

            if (giro_term) begin
              passo_d = '0;
              giros_d = giros_q - 4'd1;
            end else begin
              passo_d = passo_q + 1'b1;
            end
          end

          if (conclui) begin
            fase_d = 4'b0000;
            fim_d  = 1'b1;
          end
        end
      end

      default: ;
    endcase

    ocupado_d = (state_d == RUN);
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign fase_out            = fase_q;
  assign ocupado_out         = ocupado_q;
  assign giros_restantes_out = giros_q;
  assign fim_out             = fim_q;

endmodule

// File: tb/tb_motor_giro.sv
module tb_motor_giro;

  localparam int P = 4;
  localparam int D = 3;

  logic       clock_in;
  logic       reset_in;
  logic [3:0] numgiro_in;
  logic       sentido_in;
  logic       parada_in;
  logic [3:0] fase_out;
  logic       ocupado_out;
  logic [3:0] giros_restantes_out;
  logic       fim_out;

  int errors;
  int checks;

  motor_giro #(
    .PASSOS_POR_GIRO(P),
    .DIV_PASSO      (D)
  ) dut (
    .clock_in           (clock_in),
    .reset_in           (reset_in),
    .numgiro_in         (numgiro_in),
    .sentido_in         (sentido_in),
    .parada_in          (parada_in),
    .fase_out           (fase_out),
    .ocupado_out        (ocupado_out),
    .giros_restantes_out(giros_restantes_out),
    .fim_out            (fim_out)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0h (t=%0t)", tag, got, $time);
    end
  endtask

  // Advance one rising edge, then sample/drive 1 time unit later.
  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".ocupado"}, 32'(ocupado_out), 32'd0);
    check({tag, ".fase"},    32'(fase_out),    32'd0);
    check({tag, ".giros"},   32'(giros_restantes_out), 32'd0);
  endtask

  logic [3:0] fwd_seq [4];
  logic [3:0] rev_seq [4];

  initial begin
    errors = 0;
    checks = 0;
    fwd_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    rev_seq = '{4'b0001, 4'b1000, 4'b0100, 4'b0010};

    reset_in   = 1'b0;
    numgiro_in = 4'd0;
    sentido_in = 1'b0;
    parada_in  = 1'b0;
    tick();
    tick();
    check_idle("reset");
    check("reset.fim", 32'(fim_out), 32'd0);
    reset_in = 1'b1;

    // ---- 1: normal forward run of 2 revolutions ----
    tick();                       // key 0 seen: armed
    numgiro_in = 4'd2;
    tick();                       // accept edge
    check("t1.accept.ocupado", 32'(ocupado_out), 32'd1);
    check("t1.accept.fase",    32'(fase_out),    32'b0001);
    check("t1.accept.giros",   32'(giros_restantes_out), 32'd2);
    numgiro_in = 4'd0;
    for (int c = 1; c <= 2 * P * D; c++) begin
      tick();
      if (c < 2 * P * D) begin
        check($sformatf("t1.c%0d.fase", c),  32'(fase_out), 32'(fwd_seq[(c / D) % 4]));
        check($sformatf("t1.c%0d.giros", c), 32'(giros_restantes_out), 32'(2 - c / (P * D)));
        check($sformatf("t1.c%0d.fim", c),   32'(fim_out), 32'd0);
      end else begin
        check_idle("t1.done");
        check("t1.done.fim", 32'(fim_out), 32'd1);
      end
    end
    tick();
    check("t1.after.fim", 32'(fim_out), 32'd0);

    // ---- 2: reverse run of 1 revolution, re-press during run -> back-to-back ----
    numgiro_in = 4'd1;
    sentido_in = 1'b1;
    tick();
    check("t2.accept.ocupado", 32'(ocupado_out), 32'd1);
    check("t2.accept.giros",   32'(giros_restantes_out), 32'd1);
    numgiro_in = 4'd0;
    for (int c = 1; c <= P * D; c++) begin
      if (c == 6) begin
        numgiro_in = 4'd1;        // re-press; direction change must be ignored
        sentido_in = 1'b0;
      end
      tick();
      if (c < P * D) begin
        check($sformatf("t2.c%0d.fase", c), 32'(fase_out), 32'(rev_seq[(c / D) % 4]));
        check($sformatf("t2.c%0d.ocupado", c), 32'(ocupado_out), 32'd1);
      end else begin
        check_idle("t2.done");
        check("t2.done.fim", 32'(fim_out), 32'd1);
      end
    end
    tick();                       // back-to-back restart
    check("t2.restart.ocupado", 32'(ocupado_out), 32'd1);
    check("t2.restart.fase",    32'(fase_out),    32'b0001);
    check("t2.restart.fim",     32'(fim_out),     32'd0);
    numgiro_in = 4'd0;
    tick();
    tick();
    tick();                       // restart is forward: first step -> 0010
    check("t2.restart.fwd", 32'(fase_out), 32'b0010);
    parada_in = 1'b1;
    tick();
    parada_in = 1'b0;
    check_idle("t2.stop");

    // ---- 3: key held through reset and through completion ----
    numgiro_in = 4'd3;
    reset_in   = 1'b0;
    tick();
    reset_in = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    check("t3.held.ocupado", 32'(ocupado_out), 32'd0);
    numgiro_in = 4'd0;
    tick();
    numgiro_in = 4'd3;
    tick();
    check("t3.accept.ocupado", 32'(ocupado_out), 32'd1);
    check("t3.accept.giros",   32'(giros_restantes_out), 32'd3);
    for (int c = 1; c <= 3 * P * D; c++) tick();
    check_idle("t3.done");
    check("t3.done.fim", 32'(fim_out), 32'd1);
    for (int c = 0; c < 3; c++) tick();
    check("t3.held2.ocupado", 32'(ocupado_out), 32'd0);
    numgiro_in = 4'd0;
    tick();
    numgiro_in = 4'd3;
    tick();
    check("t3.reaccept.ocupado", 32'(ocupado_out), 32'd1);
    parada_in = 1'b1;
    tick();
    parada_in = 1'b0;
    check_idle("t3.stop");

    // ---- 4: invalid value ignored, armado kept ----
    numgiro_in = 4'd0;
    tick();
    numgiro_in = 4'd12;
    tick();
    tick();
    check_idle("t4.invalid");
    numgiro_in = 4'd5;
    tick();
    check("t4.accept.ocupado", 32'(ocupado_out), 32'd1);
    check("t4.accept.giros",   32'(giros_restantes_out), 32'd5);
    parada_in = 1'b1;
    tick();
    parada_in = 1'b0;
    check_idle("t4.stop");
    check("t4.stop.fim", 32'(fim_out), 32'd0);

    // ---- 5a: emergency stop at cycle 7 of a 2-rev run ----
    numgiro_in = 4'd0;
    tick();
    numgiro_in = 4'd2;
    tick();
    numgiro_in = 4'd0;
    for (int c = 1; c <= 6; c++) tick();
    check("t5.c6.fase", 32'(fase_out), 32'b0100);
    parada_in = 1'b1;
    tick();
    parada_in = 1'b0;
    check_idle("t5.stop");
    check("t5.stop.fim", 32'(fim_out), 32'd0);
    tick();
    check("t5.after.fim", 32'(fim_out), 32'd0);
    // parada IDLE blocks accept
    numgiro_in = 4'd1;
    parada_in  = 1'b1;
    tick();
    check("t5.block.ocupado", 32'(ocupado_out), 32'd0);
    parada_in  = 1'b0;
    numgiro_in = 4'd0;
    tick();

    // ---- 5b: stop on the completion edge -> no fim ----
    numgiro_in = 4'd1;
    tick();
    numgiro_in = 4'd0;
    for (int c = 1; c < P * D; c++) tick();
    check("t5b.pre.ocupado", 32'(ocupado_out), 32'd1);
    parada_in = 1'b1;
    tick();
    parada_in = 1'b0;
    check_idle("t5b.stop");
    check("t5b.stop.fim", 32'(fim_out), 32'd0);
    tick();
    check("t5b.after.fim", 32'(fim_out), 32'd0);

    // ---- 6: asynchronous reset mid-run, key held ----
    numgiro_in = 4'd4;
    tick();
    check("t6.accept.ocupado", 32'(ocupado_out), 32'd1);
    for (int c = 0; c < 5; c++) tick();
    #3;
    reset_in = 1'b0;
    #1;
    check_idle("t6.async");
    check("t6.async.fim", 32'(fim_out), 32'd0);
    #1;
    reset_in = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    check("t6.held.ocupado", 32'(ocupado_out), 32'd0);
    check("t6.held.fim",     32'(fim_out),     32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
